// File: rtl/vga_frota_pkg.sv
// vga_frota_pkg: shared definitions for the fleet placement controller.
//   - estado_t     : FSM states (IDLE, CHECK, DONE)
//   - erro_t       : result codes (OK, FORA, SOBREPOSTO, INVALIDO)
//   - tamanho_navio: ship id -> ship length
//   - bit-offset constants for the 64-bit renderer position vector
package vga_frota_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CHECK = 2'd1,
      DONE  = 2'd2
   } estado_t;

   typedef enum logic [1:0] {
      OK         = 2'd0,
      FORA       = 2'd1,
      SOBREPOSTO = 2'd2,
      INVALIDO   = 2'd3
   } erro_t;

   localparam int unsigned LARG_VETOR  = 64;  // bits per ship position vector
   localparam int unsigned PASSO       = 8;   // bits per cell inside the vector
   localparam int unsigned X_OFS       = 3;   // X nibble offset inside a cell
   localparam int unsigned Y_OFS       = 7;   // Y nibble offset inside a cell
   localparam int unsigned MAX_CELULAS = 5;   // longest ship
   localparam int unsigned COORD_MAX   = 8;   // board coordinates are 1..8

   // Ids beyond the table fall back to a length of 2; such ids are
   // rejected as INVALIDO before their length matters.
   function automatic logic [2:0] tamanho_navio(input logic [2:0] id);
      case (id)
         3'd0:       return 3'd2;  // submarino
         3'd1, 3'd2: return 3'd3;  // cruzador, hidroaviao
         3'd3:       return 3'd4;  // encouracado
         3'd4:       return 3'd5;  // porta-avioes
         default:    return 3'd2;
      endcase
   endfunction

endpackage

// File: rtl/vga_frota_empacota.sv
// vga_frota_empacota: combinational cell packing for one ship.
// Ports:
//   x, y     (in)  anchor cell, 1..8
//   horiz    (in)  1 = grow in +X, 0 = grow in +Y
//   tam      (in)  ship length
//   k        (in)  cell currently being examined
//   vetor    (out) packed renderer vector of the whole ship
//   mascara  (out) 64-bit occupancy mask of the whole ship
//   indice   (out) occupancy index (Y-1)*8 + (X-1) of cell k
module vga_frota_empacota
   import vga_frota_pkg::*;
(
   input  logic [3:0]  x,
   input  logic [3:0]  y,
   input  logic        horiz,
   input  logic [2:0]  tam,
   input  logic [2:0]  k,
   output logic [63:0] vetor,
   output logic [63:0] mascara,
   output logic [5:0]  indice
);

   function automatic logic [3:0] cel_x(input logic [3:0] k4);
      return horiz ? x + k4 : x;
   endfunction

   function automatic logic [3:0] cel_y(input logic [3:0] k4);
      return horiz ? y : y + k4;
   endfunction

   function automatic logic [5:0] indice_de(input logic [3:0] cx, input logic [3:0] cy);
      return ({2'b00, cy} - 6'd1) * 6'd8 + ({2'b00, cx} - 6'd1);
   endfunction

   always_comb begin
      vetor   = '0;
      mascara = '0;
      for (int unsigned c = 0; c < MAX_CELULAS; c++) begin
         if (c < 32'(tam)) begin
            vetor[c*PASSO + X_OFS +: 4]              = cel_x(4'(c));
            vetor[c*PASSO + Y_OFS +: 4]              = cel_y(4'(c));
            mascara[indice_de(cel_x(4'(c)), cel_y(4'(c)))] = 1'b1;
         end
      end
   end

   assign indice = indice_de(cel_x({1'b0, k}), cel_y({1'b0, k}));

endmodule

// File: rtl/vga_frota_controlador.sv
// vga_frota_controlador: accepts ship placement requests, checks bounds and
// overlap cell by cell, commits accepted ships and publishes their packed
// position vectors to the renderer.
// Ports:
//   clk, reset_n              clock, asynchronous active-low reset
//   req_valid / req_ready     placement request handshake
//   req_id, req_x, req_y,
//   req_horiz                 ship id, anchor cell, growth direction
//   resp_valid, resp_err      one-cycle result pulse and result code
//   clear                     synchronous fleet wipe (highest priority)
//   frame_start               start-of-vertical-blanking pulse
//   posicoes                  NAVIOS x 64-bit renderer position vectors
// Build option: VGA_FROTA_SYNC_QUADRO_EN -- when defined, posicoes only
// reloads from the shadow registers on frame_start; otherwise every cycle.
module vga_frota_controlador
   import vga_frota_pkg::*;
#(
   parameter int unsigned NAVIOS = 5
) (
   input  logic                         clk,
   input  logic                         reset_n,
   input  logic                         req_valid,
   output logic                         req_ready,
   input  logic [2:0]                   req_id,
   input  logic [3:0]                   req_x,
   input  logic [3:0]                   req_y,
   input  logic                         req_horiz,
   output logic                         resp_valid,
   output logic [1:0]                   resp_err,
   input  logic                         clear,
   input  logic                         frame_start,
   output logic [NAVIOS*LARG_VETOR-1:0] posicoes
);

   estado_t                      estado;
   logic [2:0]                   id_r;
   logic [3:0]                   x_r;
   logic [3:0]                   y_r;
   logic                         horiz_r;
   logic [2:0]                   k_r;
   logic [2:0]                   tam_r;
   logic [63:0]                  ocupacao;
   logic [7:0]                   colocado;
   logic [NAVIOS*LARG_VETOR-1:0] sombra;

   logic [63:0] vetor;
   logic [63:0] mascara;
   logic [5:0]  indice;

   logic [2:0] tam_req;
   logic [4:0] fim;
   logic       invalido;
   logic       fora;

   assign tam_r     = tamanho_navio(id_r);
   assign req_ready = reset_n && (estado == IDLE) && !clear;

   vga_frota_empacota u_empacota (
      .x       (x_r),
      .y       (y_r),
      .horiz   (horiz_r),
      .tam     (tam_r),
      .k       (k_r),
      .vetor   (vetor),
      .mascara (mascara),
      .indice  (indice)
   );

   // Capture-time classification of the incoming request.
   always_comb begin
      tam_req  = tamanho_navio(req_id);
      invalido = (32'(req_id) >= NAVIOS) || colocado[req_id];
      fim      = (req_horiz ? {1'b0, req_x} : {1'b0, req_y}) + {2'b00, tam_req} - 5'd1;
      fora     = (req_x == '0) || (req_y == '0) ||
                 (req_x > 4'(COORD_MAX)) || (req_y > 4'(COORD_MAX)) ||
                 (fim > 5'(COORD_MAX));
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         estado     <= IDLE;
         resp_valid <= 1'b0;
         resp_err   <= '0;
         id_r       <= '0;
         x_r        <= '0;
         y_r        <= '0;
         horiz_r    <= 1'b0;
         k_r        <= '0;
         ocupacao   <= '0;
         colocado   <= '0;
         sombra     <= '0;
      end else if (clear) begin
         estado     <= IDLE;
         resp_valid <= 1'b0;
         k_r        <= '0;
         ocupacao   <= '0;
         colocado   <= '0;
         sombra     <= '0;
      end else begin
         resp_valid <= 1'b0;
         unique case (estado)
            IDLE: begin
               // req_ready is implied here: reset released, clear low, IDLE.
               if (req_valid) begin
                  id_r    <= req_id;
                  x_r     <= req_x;
                  y_r     <= req_y;
                  horiz_r <= req_horiz;
                  k_r     <= '0;
                  if (invalido) begin
                     estado     <= DONE;
                     resp_valid <= 1'b1;
                     resp_err   <= INVALIDO;
                  end else if (fora) begin
                     estado     <= DONE;
                     resp_valid <= 1'b1;
                     resp_err   <= FORA;
                  end else begin
                     estado <= CHECK;
                  end
               end
            end
            CHECK: begin
               if (ocupacao[indice]) begin
                  estado     <= DONE;
                  resp_valid <= 1'b1;
                  resp_err   <= SOBREPOSTO;
               end else if (k_r == tam_r - 3'd1) begin
                  // Commit lands on the same edge that enters DONE.
                  estado     <= DONE;
                  resp_valid <= 1'b1;
                  resp_err   <= OK;
                  ocupacao   <= ocupacao | mascara;
                  colocado[id_r] <= 1'b1;
                  sombra[32'(id_r)*LARG_VETOR +: LARG_VETOR] <= vetor;
               end else begin
                  k_r <= k_r + 3'd1;
               end
            end
            DONE: estado <= IDLE;
            default: estado <= IDLE;
         endcase
      end
   end

`ifdef VGA_FROTA_SYNC_QUADRO_EN
   // Non-blocking load picks the pre-commit shadow when a commit coincides.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)         posicoes <= '0;
      else if (frame_start) posicoes <= sombra;
   end
`else
   logic unused_frame_start;
   assign unused_frame_start = frame_start;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) posicoes <= '0;
      else          posicoes <= sombra;
   end
`endif

endmodule

// File: doc/vga_frota_controlador.md
VGA_FROTA_CONTROLADOR -- requirements
Module: vga_frota_controlador

Interface
REQ-001 SHALL have parameter NAVIOS, default 5: number of ships managed; the ship ids are 0..NAVIOS-1.
REQ-002 SHALL have ports `clk` (input, 1 bit): system clock, single clock domain; all logic on its rising edge.
REQ-003 SHALL have port `reset_n` (input, 1 bit): asynchronous, active-low reset.
REQ-004 SHALL have ports `req_valid` and `req_ready`.
- `req_valid` (input, 1 bit): a placement request is present.
- `req_ready` (output, 1 bit): the controller accepts the request.
REQ-005 SHALL have request fields `req_id` (input, 3 bits), `req_x` (input, 4 bits), `req_y` (input, 4 bits) and `req_horiz` (input, 1 bit).
- `req_id` selects the ship.
- `req_x`/`req_y` are the anchor cell, board units 1..8.
- `req_horiz` = 1 grows the ship in +X; `req_horiz` = 0 grows it in +Y.
REQ-006 SHALL have ports `resp_valid` (output, 1 bit): one-cycle result pulse, and `resp_err` (output, 2 bits): result code.
REQ-007 SHALL have ports `clear` (input, 1 bit): synchronous fleet wipe, and `frame_start` (input, 1 bit): one-cycle pulse at the start of vertical blanking.
REQ-008 SHALL have port `posicoes` (output, NAVIOS×64 bits): slice i is ship i's renderer position vector.

Function
REQ-009 SHALL use fixed ship sizes:
- id0 submarino = 2
- id1 cruzador = 3
- id2 hidroaviao = 3
- id3 encouracado = 4
- id4 porta-avioes = 5
REQ-010 SHALL pack cell k (k = 0..size-1) of a ship into its 64-bit vector as X at bits [8k+6:8k+3] and Y at bits [8k+10:8k+7]; all other bits SHALL be 0.
REQ-011 SHALL encode an unused cell as X = 0, Y = 0.
REQ-012 SHALL run an FSM with the states IDLE, CHECK and DONE.
REQ-013 SHALL drive `req_ready` = 1 only when the FSM is in IDLE and `clear` = 0; a handshake occurs when `req_valid` and `req_ready` are both 1.
REQ-014 SHALL, on the handshake cycle, capture the request and move:
- to DONE with `resp_err` = 3 if `req_id` ≥ NAVIOS or the ship is already placed;
- otherwise to DONE with `resp_err` = 1 if the anchor is 0, or anchor + size − 1 > 8 on the growth axis (out of bounds);
- otherwise to CHECK.
REQ-015 SHALL, in CHECK, test one cell per cycle against a 64-bit occupancy map, in order k = 0..size-1.
REQ-016 SHALL leave CHECK for DONE with `resp_err` = 2 on the first occupied cell (early exit), or after the last cell with `resp_err` = 0.
REQ-017 SHALL assert `resp_valid` for exactly one cycle in DONE, with `resp_err` held valid in that cycle, then return to IDLE.
REQ-018 SHALL produce this latency: a request accepted at cycle T gives `resp_valid` at T+1 on an error found at capture, and at T+size+1 on success.
REQ-019 SHALL, on DONE with `resp_err` = 0, in the same edge: set the ship's occupancy bits, write its packed vector into the shadow register, and mark it placed.
REQ-020 SHALL, on any error, modify no occupancy, shadow or placed state.
REQ-021 SHALL give `clear` priority over every state: it returns the FSM to IDLE, zeroes occupancy, shadows and placed flags, and emits no `resp_valid` for an aborted request.

Reset
REQ-022 SHALL, while `reset_n` = 0, force the FSM to IDLE and drive:
- `req_ready` = 0
- `resp_valid` = 0
- `resp_err` = 0
- `posicoes` = 0
- occupancy, shadows and placed flags = 0
REQ-023 SHALL drive `req_ready` = 1 on the first cycle after `reset_n` is released.
REQ-024 SHALL, when reset is asserted mid-CHECK, produce no response and leave no partial commit.

Configuration
REQ-025 SHALL, with VGA_FROTA_SYNC_QUADRO_EN defined, load `posicoes` from the shadows only on cycles where `frame_start` = 1.
- If `frame_start` coincides with a commit, `posicoes` SHALL take the pre-commit shadow value; the commit becomes visible at the next `frame_start`.
REQ-026 SHALL, without VGA_FROTA_SYNC_QUADRO_EN, register `posicoes` from the shadows every cycle, making a commit or a clear visible 1 cycle later; `frame_start` SHALL be ignored.

Structure
REQ-027 SHALL take the ship-size table, error codes (OK = 0, FORA = 1, SOBREPOSTO = 2, INVALIDO = 3), FSM state encoding and bit-offset constants from the shared package vga_frota_pkg.
REQ-028 SHALL isolate the cell-to-vector packing and the occupancy-index calculation (index = (Y−1)·8 + (X−1)) in the combinational sub-module vga_frota_empacota.

Verification
REQ-029 SHALL cover: id4, x=2, y=3, horiz=1 → `resp_valid` at T+6 with `resp_err` = 0; `posicoes` slice 4 holds cells (2,3)..(6,3).
REQ-030 SHALL cover: id3, x=6, y=1, horiz=1 → `resp_valid` at T+1 with `resp_err` = 1; occupancy unchanged.
REQ-031 SHALL cover: after REQ-029, id1, x=4, y=2, horiz=0 → `resp_err` = 2 at T+3 (second cell (4,3) collides).
REQ-032 SHALL cover: repeating the REQ-029 request → `resp_err` = 3; also `req_id` = 6 → `resp_err` = 3.
REQ-033 SHALL cover: `clear` asserted during CHECK → no `resp_valid`, FSM in IDLE next cycle, `posicoes` = 0 (at the next `frame_start` when VGA_FROTA_SYNC_QUADRO_EN is defined).
REQ-034 SHALL cover, with VGA_FROTA_SYNC_QUADRO_EN defined: commit at cycle C with no `frame_start` → `posicoes` unchanged until the next `frame_start`; a `frame_start` at C leaves the old value until the following `frame_start`.
